mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Owns the shared memory bus between the CPU and the DMA engine. It samples the DMA bus request (BR),
//  stalls the CPU and waits for its in-flight access to drain, then grants the bus (BG).
//  When BR drops, it returns the bus to the CPU and enforces a minimum CPU slot, so DMA cycle stealing cannot starve the CPU.
//  Sits between the CPU memory port, the DMA engine and the memory; the DMA drives addr/data/offset/WRITE only while BG=1.
// PARAMETERS
//  MEM_LAT        4    memory write latency per word in cycles; power of two; defines DMA word boundaries
//  MAX_DMA_HOLD   8    DMA_OWN cycles allowed while CPU waits before a forced revoke (guard build only); >=MEM_LAT
//  MIN_CPU_SLOT   1    minimum CPU_OWN cycles after any release before BR is honoured again; >=1
// PORTS
//  CLK            in   1  system clock; all logic on posedge
//  reset          in   1  synchronous, active-high reset
//  BR             in   1  DMA bus request (level)
//  cpu_mem_req    in   1  CPU wants a memory access this cycle
//  cpu_mem_busy   in   1  CPU memory access in flight; bus must not change owner while high
//  BG             out  1  bus grant to DMA (registered)
//  cpu_stall      out  1  CPU must not start a memory access (registered)
//  bus_owner      out  1  0=CPU, 1=DMA (registered; equals BG)
//  dma_hold_cnt   out  8  cycles spent in DMA_OWN in current grant, saturates at 255
//  revoke         out  1  1-cycle pulse when grant is forcibly withdrawn (guard build only, else tied 0)
// BEHAVIOUR
//  All outputs registered. Reset (sync): state=CPU_OWN, BG=0, cpu_stall=0, bus_owner=0, dma_hold_cnt=0, revoke=0,
//   phase=0, slot_cnt=MIN_CPU_SLOT (so BR is honoured immediately after reset).
//  States:
//   CPU_OWN  : BG=0, stall=0; slot_cnt increments, saturating at MIN_CPU_SLOT.
//              BR && slot_cnt>=MIN_CPU_SLOT -> WAIT_CPU.
//   WAIT_CPU : BG=0, stall=1. !BR -> CPU_OWN (cancel; stall drops next cycle).
//              BR && !cpu_mem_busy -> DMA_OWN. Otherwise hold.
//   DMA_OWN  : BG=1, stall=1; dma_hold_cnt++ (saturating); phase=(phase+1) mod MEM_LAT.
//              !BR -> RELEASE.
//   RELEASE  : BG=0, stall=1 (one bus-turnaround cycle); BR ignored; -> CPU_OWN.
//              On entry, dma_hold_cnt, phase and slot_cnt clear to 0.
//  Latency:
//   - BR sampled high at edge N in CPU_OWN, with cpu_mem_busy low at N+1 -> BG=1 after edge N+2.
//   - BR sampled low at edge M in DMA_OWN -> BG=0 after M+1; cpu_stall=0 after M+2.
//  Boundaries:
//   - BR and cpu_mem_req both high in CPU_OWN: the DMA wins (CPU is stalled); cpu_mem_req alone never preempts.
//   - BR re-raised during RELEASE or before MIN_CPU_SLOT has elapsed: held off until the slot count is reached.
//   - cpu_mem_busy stuck high: remains in WAIT_CPU indefinitely; BG is never asserted.
//   - reset in any state: next cycle equals the reset values; BG drops immediately, with no RELEASE cycle.
//   - dma_hold_cnt saturates at 255; phase keeps wrapping independently.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - In DMA_OWN, if cpu_mem_req && dma_hold_cnt>=MAX_DMA_HOLD && phase==0 (word boundary), go to RELEASE.
//   - revoke=1 for that single cycle.
//   - The DMA keeps BR high and is re-granted via WAIT_CPU after MIN_CPU_SLOT CPU cycles.
//  ARB_STARVE_GUARD_EN undefined: no forced revoke; DMA holds the bus until BR drops; revoke constant 0.
// STRUCTURE
//  Shared package mem_bus_arb_pkg:
//   - state enum {CPU_OWN, WAIT_CPU, DMA_OWN, RELEASE}
//   - OWNER_CPU=0, OWNER_DMA=1
//   - HOLD_CNT_W=8
//  One sub-module, arb_sat_counter (param WIDTH, MAX; inc, clr), used for dma_hold_cnt and slot_cnt.
//  The phase counter and the FSM stay inline.
// TESTING
//  1. Reset with BR=1 held -> all outputs 0 at the first post-reset cycle; WAIT_CPU next; BG=1 two cycles later (cpu_mem_busy=0).
//  2. BR=1 while cpu_mem_busy=1 for 3 cycles -> cpu_stall=1 at once; BG stays 0 until 1 cycle after busy falls.
//  3. Grant, then drop BR after 12 DMA cycles -> dma_hold_cnt=12; BG=0 next cycle; cpu_stall=0 one cycle later.
//  4. MIN_CPU_SLOT=3, BR dropped then re-raised in RELEASE -> BG re-asserted no earlier than 3 CPU_OWN cycles + WAIT_CPU.
//  5. Guard build, MAX_DMA_HOLD=8, cpu_mem_req=1 from DMA cycle 2 -> revoke pulse and BG=0 after cycle 8; re-grant follows.
//  6. Non-guard build, same stimulus -> no revoke; BG held until BR drops; hold count saturates at 255 on a 300-cycle grant.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arb_pkg
// Purpose  : Shared types and constants for the CPU/DMA memory bus arbiter.
//            Arbiter state encoding, bus-owner codes and the hold-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arb_pkg;

    localparam int HOLD_CNT_W = 8;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t c_CPU_OWN  = 2'd0;
    localparam arb_state_t c_WAIT_CPU = 2'd1;
    localparam arb_state_t c_DMA_OWN  = 2'd2;
    localparam arb_state_t c_RELEASE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_sat_counter
// Purpose  : Up-counter that saturates at MAX, with synchronous clear.
//            Clear has priority over increment.
// Ports    : clk    - clock
//            rst    - synchronous active-high reset (loads RST_VAL)
//            i_inc  - increment by one unless already at MAX
//            i_clr  - force count to zero
//            o_cnt  - current count
// Revision : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX     = 255,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_RST = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_RST;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Hands the shared memory bus between the CPU and a DMA engine.
//            A DMA request stalls the CPU, waits for the CPU access in flight
//            to drain, then grants the bus. On release a one-cycle turnaround
//            is inserted and the CPU is guaranteed MIN_CPU_SLOT cycles before
//            the DMA may be granted again.
//            Optional feature macro: ARB_STARVE_GUARD_EN - when defined, a DMA
//            grant that has lasted MAX_DMA_HOLD cycles is withdrawn on a word
//            boundary if the CPU is asking for the bus.
// Ports    : CLK          in   system clock
//            reset        in   synchronous active-high reset
//            BR           in   DMA bus request (level)
//            cpu_mem_req  in   CPU wants a memory access
//            cpu_mem_busy in   CPU access in flight (no owner change)
//            BG           out  bus grant to DMA (registered)
//            cpu_stall    out  CPU must not start an access (registered)
//            bus_owner    out  0=CPU, 1=DMA (registered, equals BG)
//            dma_hold_cnt out  DMA_OWN cycles in the current grant, sat. 255
//            revoke       out  one-cycle pulse on a forced withdrawal
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int MEM_LAT      = 4,
    parameter int MAX_DMA_HOLD = 8,
    parameter int MIN_CPU_SLOT = 1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  BR,
    input  logic                  cpu_mem_req,
    input  logic                  cpu_mem_busy,
    output logic                  BG,
    output logic                  cpu_stall,
    output logic                  bus_owner,
    output logic [HOLD_CNT_W-1:0] dma_hold_cnt,
    output logic                  revoke
);

    localparam int c_PH_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int c_SLOT_W = $clog2(MIN_CPU_SLOT + 1);

    localparam logic [c_PH_W-1:0]   c_PH_LAST  = c_PH_W'(MEM_LAT - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_MIN = c_SLOT_W'(MIN_CPU_SLOT);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_bg;
    logic                    r_stall;
    logic                    r_owner;
    logic                    r_revoke;
    logic [c_PH_W-1:0]       r_phase;
    logic [HOLD_CNT_W-1:0]   w_hold_cnt;
    logic [c_SLOT_W-1:0]     w_slot_cnt;
    logic                    w_in_cpu;
    logic                    w_in_dma;
    logic                    w_in_release;
    logic                    w_slot_ok;
    logic                    w_force_revoke;

    assign w_in_cpu     = (r_state == c_CPU_OWN);
    assign w_in_dma     = (r_state == c_DMA_OWN);
    assign w_in_release = (r_state == c_RELEASE);
    assign w_slot_ok    = (w_slot_cnt >= c_SLOT_MIN);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [HOLD_CNT_W-1:0] c_HOLD_MAX = HOLD_CNT_W'(MAX_DMA_HOLD);

    // Only withdraw on a word boundary so a DMA word write is never split.
    // A plain BR drop takes the normal release path and does not pulse revoke.
    assign w_force_revoke = w_in_dma && BR && cpu_mem_req &&
                            (w_hold_cnt >= c_HOLD_MAX) && (r_phase == '0);
`else
    logic w_unused_ok;

    assign w_force_revoke = 1'b0;
    assign w_unused_ok    = ^{cpu_mem_req, r_phase, 1'(MAX_DMA_HOLD)};
`endif

    // Counts cycles spent in DMA_OWN. Cleared while in RELEASE so the final
    // grant length stays visible during the turnaround cycle.
    arb_sat_counter #(
        .WIDTH   (HOLD_CNT_W),
        .MAX     ((1 << HOLD_CNT_W) - 1),
        .RST_VAL (0)
    ) u_hold_cnt (
        .clk   (CLK),
        .rst   (reset),
        .i_inc (w_in_dma),
        .i_clr (w_in_release),
        .o_cnt (w_hold_cnt)
    );

    // CPU slot counter; resets to the full slot so BR is honoured right away.
    arb_sat_counter #(
        .WIDTH   (c_SLOT_W),
        .MAX     (MIN_CPU_SLOT),
        .RST_VAL (MIN_CPU_SLOT)
    ) u_slot_cnt (
        .clk   (CLK),
        .rst   (reset),
        .i_inc (w_in_cpu),
        .i_clr (w_in_release),
        .o_cnt (w_slot_cnt)
    );

    // Word phase within a MEM_LAT-cycle DMA write.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_phase <= '0;
        end else if (w_in_release) begin
            r_phase <= '0;
        end else if (w_in_dma) begin
            r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= c_CPU_OWN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_CPU_OWN: begin
                if (BR && w_slot_ok) begin
                    w_next_state = c_WAIT_CPU;
                end
            end
            c_WAIT_CPU: begin
                if (!BR) begin
                    w_next_state = c_CPU_OWN;
                end else if (!cpu_mem_busy) begin
                    w_next_state = c_DMA_OWN;
                end
            end
            c_DMA_OWN: begin
                if (!BR || w_force_revoke) begin
                    w_next_state = c_RELEASE;
                end
            end
            c_RELEASE: begin
                w_next_state = c_CPU_OWN;
            end
            default: begin
                w_next_state = c_CPU_OWN;
            end
        endcase
    end

    // Outputs are a registered decode of the current state, so they trail the
    // state register by one cycle; reset clears them on the same edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_bg     <= 1'b0;
            r_stall  <= 1'b0;
            r_owner  <= OWNER_CPU;
            r_revoke <= 1'b0;
        end else begin
            r_bg     <= w_in_dma;
            r_stall  <= !w_in_cpu;
            r_owner  <= w_in_dma ? OWNER_DMA : OWNER_CPU;
            r_revoke <= w_force_revoke;
        end
    end

    assign BG           = r_bg;
    assign cpu_stall    = r_stall;
    assign bus_owner    = r_owner;
    assign revoke       = r_revoke;
    assign dma_hold_cnt = w_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter (MIN_CPU_SLOT=3).
//            Stimulus pushes hand-computed expected outputs, tagged with the
//            clock cycle they apply to, into a scoreboard queue; a monitor
//            on the falling edge pops and compares them.
//            Expectations follow ARB_STARVE_GUARD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       BR;
    logic       cpu_mem_req;
    logic       cpu_mem_busy;
    logic       BG;
    logic       cpu_stall;
    logic       bus_owner;
    logic [7:0] dma_hold_cnt;
    logic       revoke;

    typedef struct {
        int          cyc;
        logic [11:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc       = 0;
    int   n_total   = 0;
    int   n_bad     = 0;
    bit   done      = 1'b0;
    bit   final_chk = 1'b0;

    mem_bus_arbiter #(
        .MEM_LAT      (4),
        .MAX_DMA_HOLD (8),
        .MIN_CPU_SLOT (3)
    ) dut (
        .CLK          (clk),
        .reset        (reset),
        .BR           (BR),
        .cpu_mem_req  (cpu_mem_req),
        .cpu_mem_busy (cpu_mem_busy),
        .BG           (BG),
        .cpu_stall    (cpu_stall),
        .bus_owner    (bus_owner),
        .dma_hold_cnt (dma_hold_cnt),
        .revoke       (revoke)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after rising edge number c: owner always mirrors BG.
    task automatic push_exp(input int c, input logic bg, input logic st,
                            input int hold, input logic rv, input string nm);
        exp_t e;
        e.cyc  = c;
        e.exp  = {bg, st, bg, rv, 8'(hold)};
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [11:0] act;
        exp_t        e;
        act = {BG, cpu_stall, bus_owner, revoke, dma_hold_cnt};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_total++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: check missed, now at cyc=%0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got bg/stall/own/rev=%b hold=%0d, want bg/stall/own/rev=%b hold=%0d",
                         e.name, cyc, act[11:8], act[7:0], e.exp[11:8], e.exp[7:0]);
            end
        end
        if (done && !final_chk) begin
            final_chk = 1'b1;
            n_total++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL sb_drain: got %0d pending checks, want 0", sb_q.size());
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout at cyc=%0d, want end of test", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int b;
        reset        = 1'b1;
        BR           = 1'b1;
        cpu_mem_req  = 1'b0;
        cpu_mem_busy = 1'b0;

        // Reset with BR held, then immediate grant and a 12-cycle hold.
        push_exp(2, 0, 0, 0, 0, "reset_vals");
        push_exp(3, 0, 0, 0, 0, "cpu_own_br_seen");
        push_exp(4, 0, 1, 0, 0, "wait_cpu");
        for (int j = 1; j <= 12; j++) push_exp(4 + j, 1, 1, j, 0, "dma_hold");
        goto(2);  reset = 1'b0;
        goto(15); BR = 1'b0;
        // BR re-raised during RELEASE: held off for three CPU_OWN cycles.
        goto(16); BR = 1'b1;
        push_exp(17, 0, 1, 0, 0, "release_turnaround");
        for (int c = 18; c <= 21; c++) push_exp(c, 0, 0, 0, 0, "min_slot_holdoff");
        push_exp(22, 0, 1, 0, 0, "wait_after_slot");
        push_exp(23, 1, 1, 1, 0, "regrant_after_slot");
        goto(23); BR = 1'b0;
        push_exp(24, 1, 1, 2, 0, "short_grant");
        push_exp(25, 0, 1, 0, 0, "short_release");
        push_exp(26, 0, 0, 0, 0, "back_to_cpu");

        // BR together with a CPU request while a CPU access is in flight.
        goto(30); BR = 1'b1; cpu_mem_busy = 1'b1; cpu_mem_req = 1'b1;
        push_exp(31, 0, 0, 0, 0, "br_with_req");
        for (int c = 32; c <= 35; c++) push_exp(c, 0, 1, 0, 0, "busy_hold_wait");
        goto(34); cpu_mem_busy = 1'b0; cpu_mem_req = 1'b0;
        push_exp(36, 1, 1, 1, 0, "grant_after_busy");
        goto(36); cpu_mem_req = 1'b1;

`ifdef ARB_STARVE_GUARD_EN
        for (int j = 2; j <= 8; j++) push_exp(35 + j, 1, 1, j, 0, "guard_hold");
        push_exp(44, 1, 1, 9, 1, "revoke_pulse");
        push_exp(45, 0, 1, 0, 0, "revoke_release");
        for (int c = 46; c <= 49; c++) push_exp(c, 0, 0, 0, 0, "revoke_cpu_slot");
        push_exp(50, 0, 1, 0, 0, "revoke_rewait");
        push_exp(51, 1, 1, 1, 0, "revoke_regrant");
        goto(51); BR = 1'b0; cpu_mem_req = 1'b0;
        push_exp(52, 1, 1, 2, 0, "guard_grant_end");
        push_exp(53, 0, 1, 0, 0, "guard_release");
        push_exp(54, 0, 0, 0, 0, "guard_cpu");
        b = 54;
`else
        for (int j = 2; j <= 300; j++)
            push_exp(35 + j, 1, 1, (j > 255) ? 255 : j, 0, "long_hold_sat");
        goto(335); BR = 1'b0; cpu_mem_req = 1'b0;
        push_exp(336, 1, 1, 255, 0, "long_grant_end");
        push_exp(337, 0, 1, 0, 0, "long_release");
        push_exp(338, 0, 0, 0, 0, "long_cpu");
        b = 338;
`endif

        // Reset while DMA owns the bus, then a cancelled WAIT_CPU.
        goto(b); BR = 1'b1;
        for (int c = b + 1; c <= b + 3; c++) push_exp(c, 0, 0, 0, 0, "slot_holdoff2");
        push_exp(b + 4, 0, 1, 0, 0, "wait3");
        push_exp(b + 5, 1, 1, 1, 0, "grant3");
        push_exp(b + 6, 1, 1, 2, 0, "grant3_hold");
        goto(b + 6); reset = 1'b1;
        push_exp(b + 7, 0, 0, 0, 0, "reset_in_dma");
        goto(b + 7); reset = 1'b0;
        push_exp(b + 8, 0, 0, 0, 0, "post_reset");
        goto(b + 8); BR = 1'b0;
        push_exp(b + 9, 0, 1, 0, 0, "wait_cancel");
        push_exp(b + 10, 0, 0, 0, 0, "cancel_stall_drop");
        goto(b + 13);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
